// File: rtl/frame_pulse_gen_pkg.sv
// Shared types and defaults for the frame pulse generator: sizing, channel and
// top-level state encodings, frame counter width.
package frame_pulse_gen_pkg;

  localparam int unsigned NCH_DEF   = 8;
  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned MAX_CH    = 8;
  localparam int unsigned FCNT_W    = 16;

  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_DELAY  = 2'd1,
    CH_ACTIVE = 2'd2,
    CH_DONE   = 2'd3
  } ch_state_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } top_state_t;

  // Completed-frame counter step; wraps 0xFFFF -> 0x0000 by construction.
  function automatic logic [FCNT_W-1:0] fcnt_inc(input logic [FCNT_W-1:0] v);
    return v + FCNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_pulse_gen_if.sv
// Bundles for the pulse generator: per-channel control bus between the top FSM
// and each pulse_channel, and the host-side parameter/status bundle.
interface pulse_ch_if
  import frame_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic [CNT_W-1:0] del;
  logic [CNT_W-1:0] dur;
  logic             launch;
  logic             clear;
  logic             fin;
  logic             pulse;

  modport master (output del, dur, launch, clear, input fin, pulse);
  modport slave  (input del, dur, launch, clear, output fin, pulse);

endinterface

interface frame_pulse_gen_if
  import frame_pulse_gen_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic              start;
  logic              abort;
  logic [CNT_W-1:0]  del [MAX_CH];
  logic [CNT_W-1:0]  dur [MAX_CH];
  logic [NCH-1:0]    pulse;
  logic              busy;
  logic              done;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (output start, abort, del, dur, input pulse, busy, done, frame_cnt);
  modport slave  (input start, abort, del, dur, output pulse, busy, done, frame_cnt);

endinterface

// File: rtl/frame_pulse_gen_pulse_channel.sv
// One pulse channel: snapshots delay/width on launch, counts the delay down,
// then holds its registered pulse high for the snapshotted width.
module pulse_channel
  import frame_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic       clk,
  input logic       rst_n,
  pulse_ch_if.slave bus
);

  ch_state_t        r_state;
  ch_state_t        w_adv;
  ch_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] r_dur_snap;
  logic             r_pulse;
  logic             w_pulse_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CH_IDLE;
      r_cnt      <= '0;
      r_dur_snap <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_pulse <= w_pulse_next;
      if (bus.launch) begin
        r_dur_snap <= bus.dur;
      end
    end
  end

  // w_adv is the free-running progression; fin is derived from it alone so the
  // top can end the frame on the same edge without a loop through clear.
  always_comb begin
    w_adv        = r_state;
    w_cnt_next   = r_cnt;
    w_pulse_next = r_pulse;
    unique case (r_state)
      CH_IDLE, CH_DONE: ;
      CH_DELAY: begin
        if (r_cnt == '0) begin
          if (r_dur_snap == '0) begin
            w_adv = CH_DONE;
          end else begin
            w_adv        = CH_ACTIVE;
            w_pulse_next = 1'b1;
            w_cnt_next   = r_dur_snap - CNT_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      CH_ACTIVE: begin
        if (r_cnt == '0) begin
          w_adv        = CH_DONE;
          w_pulse_next = 1'b0;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
    endcase

    w_next = w_adv;
    if (bus.launch) begin
      w_next       = CH_DELAY;
      w_cnt_next   = bus.del;
      w_pulse_next = 1'b0;
    end else if (bus.clear) begin
      w_next       = CH_IDLE;
      w_cnt_next   = '0;
      w_pulse_next = 1'b0;
    end
  end

  assign bus.fin   = (w_adv == CH_DONE);
  assign bus.pulse = r_pulse;

endmodule

// File: rtl/frame_pulse_gen.sv
// Multi-channel frame pulse generator: a top IDLE/RUN FSM launches NCH
// pulse_channel instances and reports busy, done and completed frames.
module frame_pulse_gen
  import frame_pulse_gen_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  del1,
  input  logic [CNT_W-1:0]  del2,
  input  logic [CNT_W-1:0]  del3,
  input  logic [CNT_W-1:0]  del4,
  input  logic [CNT_W-1:0]  del5,
  input  logic [CNT_W-1:0]  del6,
  input  logic [CNT_W-1:0]  del7,
  input  logic [CNT_W-1:0]  del8,
  input  logic [CNT_W-1:0]  dur1,
  input  logic [CNT_W-1:0]  dur2,
  input  logic [CNT_W-1:0]  dur3,
  input  logic [CNT_W-1:0]  dur4,
  input  logic [CNT_W-1:0]  dur5,
  input  logic [CNT_W-1:0]  dur6,
  input  logic [CNT_W-1:0]  dur7,
  input  logic [CNT_W-1:0]  dur8,
  output logic [NCH-1:0]    pulse,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frame_cnt
);

  top_state_t        r_state;
  top_state_t        w_state_next;
  logic              r_busy;
  logic              w_busy_next;
  logic              r_done;
  logic              w_done_next;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic [FCNT_W-1:0] w_fcnt_next;
  logic              w_launch;
  logic              w_clear;
  logic              w_all_fin;
  logic [NCH-1:0]    w_fin;
  logic [NCH-1:0]    w_pulse;
  logic [CNT_W-1:0]  w_del_all [MAX_CH];
  logic [CNT_W-1:0]  w_dur_all [MAX_CH];

  assign w_del_all[0] = del1;
  assign w_del_all[1] = del2;
  assign w_del_all[2] = del3;
  assign w_del_all[3] = del4;
  assign w_del_all[4] = del5;
  assign w_del_all[5] = del6;
  assign w_del_all[6] = del7;
  assign w_del_all[7] = del8;
  assign w_dur_all[0] = dur1;
  assign w_dur_all[1] = dur2;
  assign w_dur_all[2] = dur3;
  assign w_dur_all[3] = dur4;
  assign w_dur_all[4] = dur5;
  assign w_dur_all[5] = dur6;
  assign w_dur_all[6] = dur7;
  assign w_dur_all[7] = dur8;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    pulse_ch_if #(.CNT_W(CNT_W)) u_bus ();

    if (gi < MAX_CH) begin : g_map
      assign u_bus.del = w_del_all[gi];
      assign u_bus.dur = w_dur_all[gi];
    end else begin : g_unmapped
      assign u_bus.del = '0;
      assign u_bus.dur = '0;
    end

    assign u_bus.launch = w_launch;
    assign u_bus.clear  = w_clear;
    assign w_fin[gi]    = u_bus.fin;
    assign w_pulse[gi]  = u_bus.pulse;

    pulse_channel #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_bus.slave)
    );
  end

  assign w_all_fin = &w_fin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_frame_cnt <= w_fcnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_fcnt_next  = r_frame_cnt;
    w_launch     = 1'b0;
    w_clear      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_state_next = RUN;
          w_busy_next  = 1'b1;
          w_launch     = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
          w_clear      = 1'b1;
        end else if (w_all_fin) begin
          w_done_next = 1'b1;
          w_fcnt_next = fcnt_inc(r_frame_cnt);
          w_clear     = 1'b1;
          // A held start relaunches on the completion edge itself, so frames
          // run back to back; launch overrides clear inside each channel.
          if (start) begin
            w_launch = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_busy_next  = 1'b0;
          end
        end
      end
    endcase
  end

  assign pulse     = w_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_frame_pulse_gen.sv
// Scoreboard bench for frame_pulse_gen: directed frames push expected output
// transitions; a negedge monitor pops and compares each observed change.
module tb_frame_pulse_gen;
  import frame_pulse_gen_pkg::*;

  localparam int unsigned TB_NCH = 8;
  localparam int unsigned TB_CW  = 8;

  logic clk = 1'b0;
  logic rst_n;

  frame_pulse_gen_if #(.NCH(TB_NCH), .CNT_W(TB_CW)) hif ();

  frame_pulse_gen #(.NCH(TB_NCH), .CNT_W(TB_CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (hif.start),
    .abort     (hif.abort),
    .del1      (hif.del[0]),
    .del2      (hif.del[1]),
    .del3      (hif.del[2]),
    .del4      (hif.del[3]),
    .del5      (hif.del[4]),
    .del6      (hif.del[5]),
    .del7      (hif.del[6]),
    .del8      (hif.del[7]),
    .dur1      (hif.dur[0]),
    .dur2      (hif.dur[1]),
    .dur3      (hif.dur[2]),
    .dur4      (hif.dur[3]),
    .dur5      (hif.dur[4]),
    .dur6      (hif.dur[5]),
    .dur7      (hif.dur[6]),
    .dur8      (hif.dur[7]),
    .pulse     (hif.pulse),
    .busy      (hif.busy),
    .done      (hif.done),
    .frame_cnt (hif.frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          e;
    logic [7:0]  p;
    logic        b;
    logic        d;
    logic [15:0] fc;
  } ev_t;

  ev_t         exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          edge_no = 0;
  bit          mon_en  = 1'b0;
  logic [25:0] prev_obs;
  logic [25:0] cur_obs;

  always @(posedge clk) edge_no <= edge_no + 1;

  // Monitor: every change of {pulse,busy,done,frame_cnt} must match the next expected event.
  initial begin
    ev_t ev;
    prev_obs = '0;
    forever begin
      @(negedge clk);
      cur_obs = {hif.pulse, hif.busy, hif.done, hif.frame_cnt};
      if (mon_en && (cur_obs !== prev_obs)) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_change edge=%0d got p=%h b=%0b d=%0b fc=%h",
                   edge_no, hif.pulse, hif.busy, hif.done, hif.frame_cnt);
        end else begin
          ev = exp_q.pop_front();
          n_total++;
          if (ev.e != edge_no) begin
            n_bad++;
            $display("FAIL event_edge got edge=%0d want edge=%0d", edge_no, ev.e);
          end
          n_total++;
          if (cur_obs !== {ev.p, ev.b, ev.d, ev.fc}) begin
            n_bad++;
            $display("FAIL event_value edge=%0d got p=%h b=%0b d=%0b fc=%h want p=%h b=%0b d=%0b fc=%h",
                     edge_no, hif.pulse, hif.busy, hif.done, hif.frame_cnt,
                     ev.p, ev.b, ev.d, ev.fc);
          end
        end
      end
      prev_obs = cur_obs;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog edge=%0d", edge_no);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic expect_ev(input int e, input logic [7:0] p, input logic b,
                           input logic d, input logic [15:0] fc);
    ev_t ev;
    ev.e  = e;
    ev.p  = p;
    ev.b  = b;
    ev.d  = d;
    ev.fc = fc;
    exp_q.push_back(ev);
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain got pending=%0d want pending=0", name, exp_q.size());
      exp_q.delete();
    end
    step(2);
  endtask

  task automatic clear_params();
    for (int i = 0; i < 8; i++) begin
      hif.del[i] = '0;
      hif.dur[i] = '0;
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d, input logic [7:0] w);
    hif.del[ch-1] = d;
    hif.dur[ch-1] = w;
  endtask

  initial begin
    int n;
    int e;
    rst_n     = 1'b1;
    hif.start = 1'b0;
    hif.abort = 1'b0;
    clear_params();
    #1 rst_n = 1'b0;
    #1;
    check("reset_pulse", 32'(hif.pulse), 32'h0);
    check("reset_busy", 32'(hif.busy), 32'h0);
    check("reset_done", 32'(hif.done), 32'h0);
    check("reset_fcnt", 32'(hif.frame_cnt), 32'h0);
    step(2);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;

    // ch1 del=3 dur=2, others no pulse
    clear_params();
    set_ch(1, 8'd3, 8'd2);
    n = edge_no + 1;
    hif.start = 1'b1;
    expect_ev(n,     8'h00, 1'b1, 1'b0, 16'd0);
    expect_ev(n + 4, 8'h01, 1'b1, 1'b0, 16'd0);
    expect_ev(n + 6, 8'h00, 1'b0, 1'b1, 16'd1);
    expect_ev(n + 7, 8'h00, 1'b0, 1'b0, 16'd1);
    step();
    hif.start = 1'b0;
    drain("t1", 20);

    // all channels del=0 dur=1
    for (int i = 1; i <= 8; i++) set_ch(i, 8'd0, 8'd1);
    n = edge_no + 1;
    hif.start = 1'b1;
    expect_ev(n,     8'h00, 1'b1, 1'b0, 16'd1);
    expect_ev(n + 1, 8'hFF, 1'b1, 1'b0, 16'd1);
    expect_ev(n + 2, 8'h00, 1'b0, 1'b1, 16'd2);
    expect_ev(n + 3, 8'h00, 1'b0, 1'b0, 16'd2);
    step();
    hif.start = 1'b0;
    drain("t2", 20);

    // snapshot isolation: RAM rewritten at edge N+2
    clear_params();
    set_ch(2, 8'd5, 8'd10);
    set_ch(8, 8'd100, 8'd1);
    n = edge_no + 1;
    hif.start = 1'b1;
    expect_ev(n,       8'h00, 1'b1, 1'b0, 16'd2);
    expect_ev(n + 6,   8'h02, 1'b1, 1'b0, 16'd2);
    expect_ev(n + 16,  8'h00, 1'b1, 1'b0, 16'd2);
    expect_ev(n + 101, 8'h80, 1'b1, 1'b0, 16'd2);
    expect_ev(n + 102, 8'h00, 1'b0, 1'b1, 16'd3);
    expect_ev(n + 103, 8'h00, 1'b0, 1'b0, 16'd3);
    step();
    hif.start = 1'b0;
    step();
    for (int i = 1; i <= 8; i++) set_ch(i, 8'd1, 8'd0);
    drain("t3", 200);

    // abort mid-pulse, then abort+start in IDLE, then a full frame with a busy start
    clear_params();
    set_ch(1, 8'd2, 8'd20);
    n = edge_no + 1;
    hif.start = 1'b1;
    expect_ev(n,     8'h00, 1'b1, 1'b0, 16'd3);
    expect_ev(n + 3, 8'h01, 1'b1, 1'b0, 16'd3);
    expect_ev(n + 4, 8'h00, 1'b0, 1'b0, 16'd3);
    step();
    hif.start = 1'b0;
    step(3);
    hif.abort = 1'b1;
    step();
    hif.abort = 1'b0;
    drain("t4_abort", 10);
    hif.start = 1'b1;
    hif.abort = 1'b1;
    step();
    hif.start = 1'b0;
    hif.abort = 1'b0;
    step(3);
    check("abort_wins_busy", 32'(hif.busy), 32'h0);
    check("abort_fcnt", 32'(hif.frame_cnt), 32'd3);
    n = edge_no + 1;
    hif.start = 1'b1;
    expect_ev(n,      8'h00, 1'b1, 1'b0, 16'd3);
    expect_ev(n + 3,  8'h01, 1'b1, 1'b0, 16'd3);
    expect_ev(n + 23, 8'h00, 1'b0, 1'b1, 16'd4);
    expect_ev(n + 24, 8'h00, 1'b0, 1'b0, 16'd4);
    step();
    hif.start = 1'b0;
    step(4);
    hif.start = 1'b1;
    step();
    hif.start = 1'b0;
    drain("t4_full", 40);

    // reset mid-frame
    n = edge_no + 1;
    hif.start = 1'b1;
    expect_ev(n,     8'h00, 1'b1, 1'b0, 16'd4);
    expect_ev(n + 3, 8'h01, 1'b1, 1'b0, 16'd4);
    step();
    hif.start = 1'b0;
    drain("t_rst", 10);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pulse", 32'(hif.pulse), 32'h0);
    check("midrst_busy", 32'(hif.busy), 32'h0);
    check("midrst_done", 32'(hif.done), 32'h0);
    check("midrst_fcnt", 32'(hif.frame_cnt), 32'h0);
    step(3);
    rst_n = 1'b1;
    step();
    check("postrst_done", 32'(hif.done), 32'h0);
    check("postrst_busy", 32'(hif.busy), 32'h0);
    mon_en = 1'b1;

    // start held high: three back-to-back frames
    clear_params();
    set_ch(1, 8'd1, 8'd1);
    n = edge_no + 1;
    hif.start = 1'b1;
    expect_ev(n,      8'h00, 1'b1, 1'b0, 16'd0);
    expect_ev(n + 2,  8'h01, 1'b1, 1'b0, 16'd0);
    expect_ev(n + 3,  8'h00, 1'b1, 1'b1, 16'd1);
    expect_ev(n + 4,  8'h00, 1'b1, 1'b0, 16'd1);
    expect_ev(n + 5,  8'h01, 1'b1, 1'b0, 16'd1);
    expect_ev(n + 6,  8'h00, 1'b1, 1'b1, 16'd2);
    expect_ev(n + 7,  8'h00, 1'b1, 1'b0, 16'd2);
    expect_ev(n + 8,  8'h01, 1'b1, 1'b0, 16'd2);
    expect_ev(n + 9,  8'h00, 1'b0, 1'b1, 16'd3);
    expect_ev(n + 10, 8'h00, 1'b0, 1'b0, 16'd3);
    step(7);
    hif.start = 1'b0;
    drain("t5", 20);

    // counter maxima honoured exactly
    clear_params();
    set_ch(3, 8'd255, 8'd255);
    n = edge_no + 1;
    hif.start = 1'b1;
    expect_ev(n,       8'h00, 1'b1, 1'b0, 16'd3);
    expect_ev(n + 256, 8'h04, 1'b1, 1'b0, 16'd3);
    expect_ev(n + 511, 8'h00, 1'b0, 1'b1, 16'd4);
    expect_ev(n + 512, 8'h00, 1'b0, 1'b0, 16'd4);
    step();
    hif.start = 1'b0;
    drain("t_max", 600);

    // frame_cnt wrap via one-cycle back-to-back frames
    clear_params();
    mon_en = 1'b0;
    hif.start = 1'b1;
    for (int k = 0; k < 70000; k++) begin
      step();
      if (hif.frame_cnt == 16'hFFFF) break;
    end
    check("wrap_reach", 32'(hif.frame_cnt), 32'h0000FFFF);
    hif.start = 1'b0;
    mon_en = 1'b1;
    e = edge_no;
    expect_ev(e + 1, 8'h00, 1'b0, 1'b1, 16'h0000);
    expect_ev(e + 2, 8'h00, 1'b0, 1'b0, 16'h0000);
    drain("t_wrap", 10);
    check("wrap_final_fcnt", 32'(hif.frame_cnt), 32'h0);
    check("wrap_final_busy", 32'(hif.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_pulse_gen.md
FRAME_PULSE_GEN -- requirements
Module: frame_pulse_gen

Interface
REQ-001 SHALL have parameter NCH, default 8, number of pulse channels.
REQ-002 SHALL have parameter CNT_W, default 32, width of the delay/duration counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  frame trigger, level-sampled on clk.
REQ-006 SHALL have port abort  input  1  synchronous frame cancel.
REQ-007 SHALL have ports del1..del8  input  CNT_W each  per-channel delay in clk cycles, from parameter RAM.
REQ-008 SHALL have ports dur1..dur8  input  CNT_W each  per-channel pulse width in clk cycles, from parameter RAM.
REQ-009 SHALL have port pulse  output  NCH  registered channel outputs; bit i-1 = channel i.
REQ-010 SHALL have port busy  output  1  frame in progress.
REQ-011 SHALL have port done  output  1  one-cycle frame-complete strobe.
REQ-012 SHALL have port frame_cnt  output  16  completed-frame counter.

Function
REQ-013 Top SHALL have states IDLE and RUN; each channel SHALL have states CH_IDLE, CH_DELAY, CH_ACTIVE, CH_DONE.
REQ-014 In IDLE, start=1 sampled at edge N SHALL snapshot all del/dur into internal registers; channels enter CH_DELAY; busy=1 from edge N.
REQ-015 Snapshot SHALL isolate the frame: parameter changes after edge N SHALL NOT affect the running frame.
REQ-016 Channel i pulse SHALL be high for exactly dur_i cycles, first high cycle starting at edge N+1+del_i.
REQ-017 dur_i=0 SHALL produce no pulse; that channel reaches CH_DONE at edge N+1+del_i.
REQ-018 del_i=0 SHALL start the pulse at edge N+1.
REQ-019 Counters SHALL be unsigned CNT_W down-counters with no wrap; max values (2^CNT_W-1) SHALL be honoured exactly.
REQ-020 The edge at which the last channel reaches CH_DONE SHALL return the top FSM to IDLE, drop busy, assert done for one cycle, increment frame_cnt, and return all channels to CH_IDLE.
REQ-021 frame_cnt SHALL wrap 0xFFFF -> 0x0000.
REQ-022 start while in RUN SHALL be ignored; no queuing.
REQ-023 start held high SHALL retrigger at the first edge in IDLE after done, i.e. back-to-back frames with zero idle cycles.
REQ-024 abort=1 at any edge in RUN SHALL clear pulse to 0, busy to 0, all channels to CH_IDLE at that edge; no done, frame_cnt unchanged.
REQ-025 abort and start both high in IDLE: abort SHALL win; no frame starts.
REQ-026 Outputs SHALL be glitch-free registers; no combinational path from inputs to pulse/busy/done.

Reset
REQ-027 rst_n=0 SHALL asynchronously force pulse=0, busy=0, done=0, frame_cnt=0, top FSM IDLE, channels CH_IDLE, counters and snapshots 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no done strobe; first start after rst_n release begins a fresh frame.

Structure
REQ-029 Shared package SHALL hold NCH, CNT_W defaults, the channel state encoding, and the frame_cnt width.
REQ-030 One sub-module pulse_channel (snapshot, down-counter, 4-state FSM, pulse register) SHALL be instantiated NCH times; top holds top FSM, done/busy logic, frame_cnt.

Verification
REQ-031 ch1 del=3 dur=2, others dur=0, start sampled at edge 10 -> pulse[0] high after edges 14,15, low after 16; done one cycle at edge 16; frame_cnt 0->1.
REQ-032 All channels del=0 dur=1 -> all pulse bits high at edge N+1 only; done at edge N+2.
REQ-033 ch2 del=5 dur=10, ch8 del=100 dur=1; change RAM values at edge N+2 -> pulses match original values; busy low at edge N+102.
REQ-034 abort at edge N+4 during ch1 del=2 dur=20 -> pulse[0] 0 from edge N+4, busy 0, no done, frame_cnt unchanged; later start runs full frame.
REQ-035 start held high, ch1 del=1 dur=1 for 3 frames -> pulses at edges N+2, N+5, N+8; frame_cnt=3; start pulses while busy ignored.
REQ-036 frame_cnt preset via 65535 frames (or forced) -> next done wraps to 0; rst_n low mid-frame -> all outputs 0 immediately, no done.
